// File: rtl/sync_t_downcounter_nonlinear_if.sv
// Control/status bundle for the nonlinear down-counter: the master drives the
// count controls and observes the counter state.
interface sync_t_downcounter_nonlinear_if;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic [2:0] idx;
    logic       tc;
    logic       err;

    modport master (
        output en,
        output load,
        output load_val,
        input  q,
        input  idx,
        input  tc,
        input  err
    );

    modport slave (
        input  en,
        input  load,
        input  load_val,
        output q,
        output idx,
        output tc,
        output err
    );
endinterface

// File: rtl/sync_t_downcounter_nonlinear.sv
// Down-counter over the sequence 13,11,7,5,3,2,1 with load, illegal-load flag,
// position index and terminal count. WRAP selects wrap-to-13 or saturate at 1.
module sync_t_downcounter_nonlinear #(
    parameter int WRAP = 1
) (
    input  logic clk,
    input  logic clear,
    sync_t_downcounter_nonlinear_if.slave bus
);
    // Element gi of the sequence sits at bits [gi*4 +: 4]; element 0 is 13.
    localparam logic [27:0] SEQ = {4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13};
    localparam logic [3:0]  TOP = 4'd13;

    logic [3:0] q_q, q_d;
    logic       err_q, err_d;
    logic [6:0] q_hit;
    logic [6:0] ld_hit;
    logic [3:0] step_val;
    logic [2:0] idx_c;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_match
            assign q_hit[gi]  = (q_q == SEQ[gi*4 +: 4]);
            assign ld_hit[gi] = (bus.load_val == SEQ[gi*4 +: 4]);
        end
    endgenerate

    // Successor of the current value; anything illegal recovers to the top.
    always_comb begin
        step_val = TOP;
        for (int k = 0; k < 6; k++) begin
            if (q_hit[k]) step_val = SEQ[(k+1)*4 +: 4];
        end
        if (q_hit[6]) step_val = (WRAP != 0) ? TOP : 4'd1;
    end

    always_comb begin
        idx_c = 3'd7;
        for (int k = 0; k < 7; k++) begin
            if (q_hit[k]) idx_c = k[2:0];
        end
    end

    always_comb begin
        q_d   = q_q;
        err_d = 1'b0;
        if (bus.load) begin
            if (|ld_hit) begin
                q_d = bus.load_val;
            end else begin
                q_d   = TOP;
                err_d = 1'b1;
            end
        end else if (bus.en) begin
            q_d = step_val;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            q_q   <= TOP;
            err_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    assign bus.q   = q_q;
    assign bus.err = err_q;
    assign bus.idx = idx_c;
    assign bus.tc  = q_hit[6] & bus.en & ~bus.load & ~clear;
endmodule
